// File: rtl/inst_fetch_if.sv
// inst_fetch_if: instruction-memory request/response channel between fetch and memory.
interface inst_fetch_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;
  modport master (output req, output addr, input ack, input rdata);
  modport slave (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/inst_fetch.sv
// inst_fetch: IF stage with a one-entry back-pressure buffer and in-flight request draining.
module inst_fetch (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          stall,
  input  logic                flush_i,
  input  logic [31:0]         pc_i,
  input  logic                ce_i,
  inst_fetch_if.master        imem,
  output logic                stallreq_o,
  output logic [31:0]         id_pc_o,
  output logic [31:0]         id_inst_o
);
  typedef enum logic [1:0] {IDLE, FETCH, READY, DRAIN} state_e;
  state_e      state_q, state_d;
  logic [31:0] req_addr_q, buf_pc_q, buf_inst_q;
  logic [31:0] id_pc_q, id_inst_q, id_pc_d, id_inst_d;
  logic        fetch_ack;
  logic        unused_stall;
  assign unused_stall = ^{stall[5:3], stall[0]};
  assign id_pc_o = id_pc_q;
  assign id_inst_o = id_inst_q;
  always_ff @(posedge clk)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  // An unacked request must stay on the bus, so flush without ack drains it first.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = ce_i ? FETCH : IDLE;
      FETCH:   state_d = (flush_i && !imem.ack) ? DRAIN :
                         !ce_i ? IDLE :
                         (imem.ack && stall[1] && !flush_i) ? READY : FETCH;
      READY:   state_d = !ce_i ? IDLE : (flush_i || !stall[1]) ? FETCH : READY;
      DRAIN:   state_d = !imem.ack ? DRAIN : ce_i ? FETCH : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    fetch_ack = state_q == FETCH && imem.ack;
    imem.req = !rst && (state_q == FETCH || state_q == DRAIN);
    imem.addr = (state_q == DRAIN) ? req_addr_q : pc_i;
    stallreq_o = !rst && (state_q == DRAIN || (state_q == FETCH && !imem.ack));
    id_pc_d = flush_i ? '0 :
              stall[1] ? (stall[2] ? id_pc_q : '0) :
              fetch_ack ? pc_i :
              (state_q == READY) ? buf_pc_q : '0;
    id_inst_d = flush_i ? '0 :
                stall[1] ? (stall[2] ? id_inst_q : '0) :
                fetch_ack ? imem.rdata :
                (state_q == READY) ? buf_inst_q : '0;
  end
  always_ff @(posedge clk)
    if (rst) begin
      req_addr_q <= '0;
      buf_pc_q <= '0;
      buf_inst_q <= '0;
      id_pc_q <= '0;
      id_inst_q <= '0;
    end else begin
      id_pc_q <= id_pc_d;
      id_inst_q <= id_inst_d;
      if (state_q == FETCH) req_addr_q <= pc_i;
      if (fetch_ack && stall[1] && !flush_i) begin
        buf_pc_q <= pc_i;
        buf_inst_q <= imem.rdata;
      end
    end
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed scenarios plus randomized traffic checked against a behavioural model.
module tb_inst_fetch;
  logic        clk, rst, flush, ce, ack;
  logic [5:0]  stall;
  logic [31:0] pc, rdata, id_pc, id_inst;
  logic        stallreq;
  int          n_cmp = 0, n_bad = 0;
  inst_fetch_if imem ();
  assign imem.ack = ack;
  assign imem.rdata = rdata;
  inst_fetch dut (
    .clk(clk), .rst(rst), .stall(stall), .flush_i(flush), .pc_i(pc), .ce_i(ce),
    .imem(imem), .stallreq_o(stallreq), .id_pc_o(id_pc), .id_inst_o(id_inst)
  );
  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: engine running, instruction parked, or old request still in flight.
  bit          started = 0, m_run = 0, m_held = 0, m_drain = 0;
  logic [31:0] m_addr = 0, m_bpc = 0, m_binst = 0, m_pc = 0, m_inst = 0;

  always @(posedge clk) begin
    bit fetching, have;
    if (rst) begin
      started = 1; m_run = 0; m_held = 0; m_drain = 0;
      m_addr = 0; m_bpc = 0; m_binst = 0; m_pc = 0; m_inst = 0;
    end else if (started) begin
      fetching = m_run && !m_held && !m_drain;
      have = (fetching && ack) || m_held;
      if (flush || (stall[1] && !stall[2]) || (!stall[1] && !have)) begin
        m_pc = 0; m_inst = 0;
      end else if (!stall[1]) begin
        m_pc = m_held ? m_bpc : pc;
        m_inst = m_held ? m_binst : rdata;
      end
      if (m_drain) begin
        if (ack) begin m_drain = 0; m_run = ce; end
      end else if (fetching) begin
        if (flush && !ack) begin m_drain = 1; m_addr = pc; end
        else if (!ce) m_run = 0;
        else if (!flush && ack && stall[1]) begin m_held = 1; m_bpc = pc; m_binst = rdata; end
      end else if (m_held) begin
        if (!ce) begin m_run = 0; m_held = 0; end
        else if (flush || !stall[1]) m_held = 0;
      end else m_run = ce;
    end
  end

  always @(negedge clk) if (started) begin
    bit fetching, e_req;
    fetching = m_run && !m_held && !m_drain;
    e_req = !rst && (m_drain || fetching);
    check("req", {31'b0, imem.req}, {31'b0, e_req});
    check("stallreq", {31'b0, stallreq}, {31'b0, !rst && (m_drain || (fetching && !ack))});
    if (e_req) check("addr", imem.addr, m_drain ? m_addr : pc);
    check("id_pc", id_pc, m_pc);
    check("id_inst", id_inst, m_inst);
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; ce = 0; flush = 0; stall = 0; pc = 0; ack = 0; rdata = 0;
    step; step;
    check("rst_id_pc", id_pc, 0); check("rst_id_inst", id_inst, 0);
    check("rst_req", {31'b0, imem.req}, 0); check("rst_stallreq", {31'b0, stallreq}, 0);
    rst = 0; ce = 1; pc = 0;
    step;
    ack = 1; rdata = 32'hA000_0001; #1;
    check("zw_stallreq0", {31'b0, stallreq}, 0);
    step; check("zw_inst_a", id_inst, 32'hA000_0001); check("zw_pc_a", id_pc, 0);
    pc = 4; rdata = 32'hB000_0002; #1;
    check("zw_stallreq1", {31'b0, stallreq}, 0);
    step; check("zw_inst_b", id_inst, 32'hB000_0002); check("zw_pc_b", id_pc, 4);
    pc = 8; rdata = 32'hC000_0003;
    step; check("zw_inst_c", id_inst, 32'hC000_0003); check("zw_pc_c", id_pc, 8);
    pc = 32'h10; ack = 0; #1;
    check("ws_stallreq_1", {31'b0, stallreq}, 1); check("ws_addr_1", imem.addr, 32'h10);
    step; check("ws_bubble_1", id_inst, 0);
    check("ws_stallreq_2", {31'b0, stallreq}, 1); check("ws_addr_2", imem.addr, 32'h10);
    step; check("ws_bubble_2", id_inst, 0);
    ack = 1; rdata = 32'h1111_0010;
    step; check("ws_pc", id_pc, 32'h10); check("ws_inst", id_inst, 32'h1111_0010);
    pc = 32'h14; rdata = 32'h0000_DEAD; stall = 6'b000011;
    step; check("bp_bubble", id_inst, 0);
    ack = 0; #1;
    check("bp_req", {31'b0, imem.req}, 0); check("bp_stallreq", {31'b0, stallreq}, 0);
    step; check("bp_bubble2", id_inst, 0);
    stall = 0;
    step; check("bp_inst", id_inst, 32'h0000_DEAD); check("bp_pc", id_pc, 32'h14);
    pc = 32'h20;
    step;
    flush = 1;
    step; check("fl_bubble", id_inst, 0);
    flush = 0; pc = 32'h80; #1;
    check("fl_req", {31'b0, imem.req}, 1); check("fl_addr_held", imem.addr, 32'h20);
    step;
    ack = 1; rdata = 32'h0000_0BAD; #1;
    check("fl_addr_ack", imem.addr, 32'h20);
    step; check("fl_dropped", id_inst, 0);
    ack = 0; #1;
    check("fl_next_addr", imem.addr, 32'h80); check("fl_next_req", {31'b0, imem.req}, 1);
    flush = 1;
    step;
    flush = 0; #1;
    check("rd_drain_req", {31'b0, imem.req}, 1);
    rst = 1;
    step;
    check("rd_req", {31'b0, imem.req}, 0); check("rd_pc", id_pc, 0); check("rd_inst", id_inst, 0);
    rst = 0; ack = 1; rdata = 32'h0000_0123;
    step; check("rd_late_ack", id_inst, 0);
    pc = 32'h40; rdata = 32'h0000_5A5A;
    step; check("hd_load", id_inst, 32'h0000_5A5A);
    stall = 6'b000111; pc = 32'h44; rdata = 32'h0000_6B6B;
    for (int i = 0; i < 3; i++) begin
      step; check("hd_inst", id_inst, 32'h0000_5A5A); check("hd_pc", id_pc, 32'h40);
    end
    stall = 6'b000011;
    step; check("hd_bubble_inst", id_inst, 0); check("hd_bubble_pc", id_pc, 0);
    stall = 0; ack = 0;
    step; check("hd_buf_inst", id_inst, 32'h0000_6B6B); check("hd_buf_pc", id_pc, 32'h44);
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom % 64) == 0;
      flush = ($urandom % 8) == 0;
      ce = ($urandom % 10) != 0;
      ack = $urandom % 2;
      stall = 6'($urandom);
      stall[1] = ($urandom % 3) == 0;
      stall[2] = ($urandom % 3) == 0;
      pc = $urandom & ~32'h3;
      rdata = $urandom;
      step;
    end
    step;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have ports: clk  in  1  clock; all state updates on rising edge.
REQ-002 SHALL have: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have: stall  in  6  pipeline stall vector; bit0 = PC, bit1 = IF, bit2 = ID; 1 = stop.
REQ-004 SHALL have: flush_i  in  1  discard all fetch state this cycle.
REQ-005 SHALL have: pc_i  in  32  fetch address from the PC register.
REQ-006 SHALL have: ce_i  in  1  fetch enable from the PC register.
REQ-007 SHALL have: imem_req_o  out  1  memory request.
REQ-008 SHALL have: imem_addr_o  out  32  memory address.
REQ-009 SHALL have: imem_ack_i  in  1  data valid this cycle.
REQ-010 SHALL have: imem_rdata_i  in  32  instruction word.
REQ-011 SHALL have: stallreq_o  out  1  IF stall request to the stall controller; combinational.
REQ-012 SHALL have: id_pc_o  out  32  registered PC of the instruction presented to ID.
REQ-013 SHALL have: id_inst_o  out  32  registered instruction presented to ID.

Function
REQ-014 SHALL implement FSM states IDLE, FETCH, READY, DRAIN.
REQ-015 SHALL leave IDLE for FETCH when ce_i=1; any state goes to IDLE when ce_i=0, except DRAIN, which completes first.
REQ-016 SHALL drive imem_req_o=1 only in FETCH and DRAIN.
REQ-017 SHALL drive imem_addr_o=pc_i in FETCH and the latched req_addr in DRAIN.
REQ-018 SHALL latch req_addr<=pc_i on every FETCH cycle.
REQ-019 SHALL drive stallreq_o=1 in DRAIN, and in FETCH when imem_ack_i=0; 0 otherwise.
REQ-020 FETCH with ack and stall[1]=0: SHALL load id_pc_o<=pc_i and id_inst_o<=imem_rdata_i at that edge, and stay in FETCH; zero-wait memory gives 1 instr/cycle.
REQ-021 FETCH with ack and stall[1]=1: SHALL capture buf_pc<=pc_i and buf_inst<=imem_rdata_i, and go to READY.
REQ-022 READY: SHALL keep imem_req_o=0 and stallreq_o=0; when stall[1]=0, SHALL load the ID outputs from buf and go to FETCH.
REQ-023 IF/ID outputs with stall[1]=1, stall[2]=0: SHALL load a bubble (id_pc_o=0, id_inst_o=0).
REQ-024 IF/ID outputs with stall[1]=1, stall[2]=1: SHALL hold their values.
REQ-025 IF/ID outputs with stall[1]=0 and no instruction delivered (IDLE, DRAIN, or FETCH without ack): SHALL load a bubble.
REQ-026 flush_i=1 SHALL override stall and load a bubble into the ID outputs.
REQ-027 flush_i=1 in FETCH without ack: SHALL go to DRAIN, because a request once raised stays asserted with a stable address until ack.
REQ-028 flush_i=1 in FETCH with ack, or in READY: SHALL discard the data and go to FETCH.
REQ-029 flush_i=1 in DRAIN: SHALL remain in DRAIN.
REQ-030 DRAIN with ack: SHALL discard imem_rdata_i and go to FETCH, or to IDLE if ce_i=0.
REQ-031 imem_ack_i in IDLE or READY SHALL be ignored.
REQ-032 Simultaneous ack and flush SHALL resolve as flush.

Reset
REQ-033 rst=1 SHALL force IDLE, imem_req_o=0, stallreq_o=0, id_pc_o=0, id_inst_o=0, buf_pc=0, buf_inst=0, req_addr=0.
REQ-034 rst SHALL take priority over flush_i, stall and ack, including mid-DRAIN; a late ack after reset SHALL be ignored.

Verification
REQ-035 Zero-wait stream: ce_i=1, ack every cycle, pc_i 0,4,8 with data A,B,C -> id_inst_o A,B,C on consecutive cycles; stallreq_o=0 throughout.
REQ-036 Wait states: ack two cycles after req at pc_i=0x10 -> stallreq_o=1 for 2 cycles; imem_addr_o stays 0x10; ID gets bubbles, then pc 0x10 with the data.
REQ-037 Back-pressure: ack with data 0xDEAD while stall=6'b000011 from a later stage -> READY; req low; ID bubble; release stall -> id_inst_o=0xDEAD, id_pc_o=buf_pc.
REQ-038 Flush in flight: req at 0x20 unacked, flush_i pulse, pc_i changes to 0x80 -> req held at 0x20 until ack; data dropped; next request at 0x80; ID bubble.
REQ-039 Reset mid-DRAIN: rst=1 during DRAIN -> next cycle imem_req_o=0, all outputs 0; ack the following cycle leaves id_inst_o=0.
REQ-040 Hold: stall=6'b000111 for 3 cycles with id_inst_o=X -> id_inst_o and id_pc_o unchanged; stall=6'b000011 -> bubble next cycle.
